// File: rtl/spike_readout_if.sv
// Event stream from the spike readout to the host: {timestamp, neuron_addr} with valid/ready.
interface spike_readout_if #(
  parameter int ADDR_W = 4,
  parameter int TS_W   = 12
);
  logic                     evt_valid;
  logic                     evt_ready;
  logic [ADDR_W+TS_W-1:0]   evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/spike_readout.sv
// Drains the output spike FIFO, timestamps each event onto a valid/ready stream,
// and keeps per-neuron saturating spike counters readable by the host.
module spike_readout #(
  parameter int NEURONS = 16,
  parameter int ADDR_W  = 4,
  parameter int TS_W    = 12,
  parameter int CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               snn_event_n,
  input  logic [ADDR_W-1:0]  neuron_addr_in,
  output logic               snn_ren,
  input  logic               timestep_tick,
  spike_readout_if.master    evt,
  input  logic [ADDR_W-1:0]  cnt_rd_addr,
  output logic [CNT_W-1:0]   cnt_rd_data,
  input  logic               cnt_clear,
  output logic               cnt_sat
);

  typedef enum logic [1:0] {IDLE, POP, CAPTURE, SEND} state_t;

  state_t                         state, state_nxt;
  logic [TS_W-1:0]                ts;
  logic [ADDR_W+TS_W-1:0]         data;
  logic [NEURONS-1:0][CNT_W-1:0]  cnt;
  logic [NEURONS-1:0]             sat_hit;
  logic [CNT_W-1:0]               rd_val;
  logic                           capture;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FIFO dout is valid in CAPTURE, one cycle after the POP strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!snn_event_n) state_nxt = POP;
      POP:     state_nxt = CAPTURE;
      CAPTURE: state_nxt = SEND;
      SEND:    if (evt.evt_ready) state_nxt = snn_event_n ? IDLE : POP;
      default: state_nxt = IDLE;
    endcase
  end

  assign snn_ren       = (state == POP);
  assign evt.evt_valid = (state == SEND);
  assign evt.evt_data  = data;
  assign capture       = (state == CAPTURE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)              ts <= '0;
    else if (timestep_tick) ts <= ts + 1'b1;
  end

  // Stamp uses the current register value, so a coincident tick lands on the next event.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        data <= '0;
    else if (capture) data <= {ts, neuron_addr_in};
  end

  for (genvar i = 0; i < NEURONS; i++) begin : g_cnt
    logic             hit;
    logic [CNT_W-1:0] val;

    assign hit        = capture && (neuron_addr_in == ADDR_W'(i));
    assign sat_hit[i] = hit && (val == '1);
    assign cnt[i]     = val;

    always_ff @(posedge clock or posedge reset) begin
      if (reset)                   val <= '0;
      else if (cnt_clear)          val <= '0;
      else if (hit && val != '1)   val <= val + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          cnt_sat <= 1'b0;
    else if (cnt_clear) cnt_sat <= 1'b0;
    else if (|sat_hit)  cnt_sat <= 1'b1;
  end

  // Addresses with no matching neuron fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NEURONS; i++)
      if (cnt_rd_addr == ADDR_W'(i)) rd_val = cnt[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_rd_data <= '0;
    else       cnt_rd_data <= rd_val;
  end

endmodule

// File: tb/tb_spike_readout.sv
// Scoreboard bench for spike_readout: FIFO model feeds addresses, monitor checks the event stream.
module tb_spike_readout;
  localparam int NEURONS = 16, ADDR_W = 4, TS_W = 12, CNT_W = 8;
  localparam int DW = ADDR_W + TS_W;

  logic              clock = 1'b0, reset = 1'b1;
  logic              snn_event_n = 1'b1, snn_ren, timestep_tick = 1'b0;
  logic              cnt_clear = 1'b0, cnt_sat;
  logic [ADDR_W-1:0] neuron_addr_in = '0, cnt_rd_addr = '0;
  logic [CNT_W-1:0]  cnt_rd_data;

  spike_readout_if #(.ADDR_W(ADDR_W), .TS_W(TS_W)) evt ();

  spike_readout #(.NEURONS(NEURONS), .ADDR_W(ADDR_W), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .snn_event_n(snn_event_n), .neuron_addr_in(neuron_addr_in),
    .snn_ren(snn_ren), .timestep_tick(timestep_tick), .evt(evt), .cnt_rd_addr(cnt_rd_addr),
    .cnt_rd_data(cnt_rd_data), .cnt_clear(cnt_clear), .cnt_sat(cnt_sat)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0, cyc = 0, ren_cnt = 0;
  logic [ADDR_W-1:0] fifo_q[$];
  logic [DW-1:0]     exp_q[$];
  int                ren_cyc[$];
  logic [TS_W-1:0]   ts_m = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: dout updates on the edge that samples snn_ren.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (snn_ren) begin
      ren_cnt <= ren_cnt + 1;
      ren_cyc.push_back(cyc);
      chk("ren_while_empty", 32'(snn_event_n), 32'd0);
      if (fifo_q.size() != 0) neuron_addr_in <= fifo_q.pop_front();
      if (fifo_q.size() == 0) snn_event_n <= 1'b1;
    end
  end

  always begin : mon
    logic [DW-1:0] e;
    @(negedge clock);
    #1;
    if (evt.evt_valid && evt.evt_ready && !reset) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_evt: got %0h expected none", evt.evt_data);
      end else begin
        e = exp_q.pop_front();
        chk("evt_data", 32'(evt.evt_data), 32'(e));
      end
    end
  end

  task automatic push(input logic [ADDR_W-1:0] a);
    fifo_q.push_back(a);
    exp_q.push_back({ts_m, a});
    snn_event_n = 1'b0;
  endtask

  task automatic push_noexp(input logic [ADDR_W-1:0] a);
    fifo_q.push_back(a);
    snn_event_n = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || evt.evt_valid) && n < 3000) begin
      @(negedge clock); n++;
    end
    chk("drain_timeout", 32'(n < 3000), 32'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] exp);
    @(negedge clock);
    cnt_rd_addr = a;
    @(negedge clock);
    chk($sformatf("cnt[%0d]", a), 32'(cnt_rd_data), 32'(exp));
  endtask

  task automatic ticks(input int n);
    @(negedge clock);
    timestep_tick = 1'b1;
    repeat (n) @(negedge clock);
    timestep_tick = 1'b0;
    ts_m = ts_m + TS_W'(n);
  endtask

  task automatic wait_ren();
    int n = 0;
    while (!snn_ren && n < 50) begin @(negedge clock); n++; end
    chk("wait_ren_timeout", 32'(n < 50), 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!evt.evt_valid && n < 50) begin @(negedge clock); n++; end
    chk("wait_valid_timeout", 32'(n < 50), 32'd1);
  endtask

  initial begin
    int r0;
    logic stable;
    evt.evt_ready = 1'b0;
    #12;
    chk("rst_ren", 32'(snn_ren), 32'd0);
    chk("rst_valid", 32'(evt.evt_valid), 32'd0);
    chk("rst_data", 32'(evt.evt_data), 32'd0);
    chk("rst_rd_data", 32'(cnt_rd_data), 32'd0);
    chk("rst_sat", 32'(cnt_sat), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    evt.evt_ready = 1'b1;

    // single event latency
    @(negedge clock);
    push(4'd5);
    @(negedge clock); chk("lat_ren_c1", 32'(snn_ren), 32'd1);
    @(negedge clock); chk("lat_ren_c2", 32'(snn_ren), 32'd0);
    chk("lat_valid_c2", 32'(evt.evt_valid), 32'd0);
    @(negedge clock); chk("lat_valid_c3", 32'(evt.evt_valid), 32'd1);
    drain();
    rd(4'd5, 8'd1);

    // back-to-back pops
    ren_cyc.delete();
    push(4'd2); push(4'd7); push(4'd2);
    drain();
    chk("b2b_pops", 32'(ren_cyc.size()), 32'd3);
    if (ren_cyc.size() == 3) begin
      chk("b2b_gap0", 32'(ren_cyc[1] - ren_cyc[0]), 32'd3);
      chk("b2b_gap1", 32'(ren_cyc[2] - ren_cyc[1]), 32'd3);
    end
    rd(4'd2, 8'd2);
    rd(4'd7, 8'd1);

    // backpressure
    evt.evt_ready = 1'b0;
    r0 = ren_cnt;
    push(4'd1); push(4'd4); push(4'd6); push(4'd8);
    wait_valid();
    stable = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (!evt.evt_valid || evt.evt_data !== {ts_m, 4'd1}) stable = 1'b0;
    end
    chk("bp_single_pop", 32'(ren_cnt - r0), 32'd1);
    chk("bp_stable", 32'(stable), 32'd1);
    evt.evt_ready = 1'b1;
    drain();
    chk("bp_total_pops", 32'(ren_cnt - r0), 32'd4);
    rd(4'd8, 8'd1);

    // saturation and clear
    for (int i = 0; i < 255; i++) push(4'd3);
    drain();
    rd(4'd3, 8'd255);
    chk("sat_at_max", 32'(cnt_sat), 32'd0);
    push(4'd3);
    drain();
    rd(4'd3, 8'd255);
    chk("sat_over", 32'(cnt_sat), 32'd1);
    @(negedge clock); cnt_clear = 1'b1;
    @(negedge clock); cnt_clear = 1'b0;
    chk("sat_cleared", 32'(cnt_sat), 32'd0);
    rd(4'd3, 8'd0);
    rd(4'd5, 8'd0);
    push(4'd3);
    wait_ren();
    @(negedge clock); cnt_clear = 1'b1;
    @(negedge clock); cnt_clear = 1'b0;
    drain();
    rd(4'd3, 8'd0);

    // timestamp wrap and tick during capture
    ticks(4095);
    push(4'd9);
    drain();
    ticks(1);
    push(4'd10);
    drain();
    push(4'd11);
    wait_ren();
    @(negedge clock); timestep_tick = 1'b1;
    @(negedge clock); timestep_tick = 1'b0;
    ts_m = ts_m + 1'b1;
    drain();
    push(4'd12);
    drain();

    // async reset while holding SEND
    evt.evt_ready = 1'b0;
    push_noexp(4'd13);
    wait_valid();
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(evt.evt_valid), 32'd0);
    chk("arst_ren", 32'(snn_ren), 32'd0);
    chk("arst_data", 32'(evt.evt_data), 32'd0);
    chk("arst_rd_data", 32'(cnt_rd_data), 32'd0);
    ts_m = '0;
    @(negedge clock);
    reset = 1'b0;
    r0 = ren_cnt;
    repeat (5) @(negedge clock);
    chk("arst_no_pop", 32'(ren_cnt - r0), 32'd0);
    rd(4'd13, 8'd0);
    rd(4'd7, 8'd0);
    evt.evt_ready = 1'b1;
    push(4'd14);
    drain();
    rd(4'd14, 8'd1);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spike_readout.md
Name: spike_readout

Overview:
Consumer end of the output spike-event FIFO. It drains neuron addresses popped from the FIFO, stamps each one with a timestep counter, and presents it on a valid/ready stream to the host or an off-chip link. It also keeps per-neuron saturating spike counters that the host can read. It sits between the SNN core's out_fifo (snn_ren/snn_event_n/neuron_addr_out) and the host interface.

Parameters:
NEURONS, 16, number of neurons; the counter array size.
ADDR_W, 4, neuron address width; must equal clog2(NEURONS).
TS_W, 12, timestamp counter width.
CNT_W, 8, per-neuron spike counter width.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
snn_event_n  input  1  FIFO empty flag; 0 means at least one event is queued.
neuron_addr_in  input  ADDR_W  FIFO dout; valid exactly 1 cycle after snn_ren is high.
snn_ren  output  1  FIFO pop strobe; one cycle per event.
timestep_tick  input  1  single-cycle pulse that advances the timestamp.
evt_valid  output  1  event available on evt_data.
evt_ready  input  1  downstream accepts the event.
evt_data  output  ADDR_W+TS_W  {timestamp, neuron_addr}, with the address in the LSBs.
cnt_rd_addr  input  ADDR_W  counter read address.
cnt_rd_data  output  CNT_W  counter value, registered, 1-cycle latency.
cnt_clear  input  1  synchronous clear of all counters and of cnt_sat.
cnt_sat  output  1  sticky flag; set when any counter saturates.

Behaviour:
- Reset (async, while reset=1):
  - state=IDLE; snn_ren=0, evt_valid=0, evt_data=0, cnt_rd_data=0, cnt_sat=0.
  - Timestamp=0; all counters=0.
  - An event already popped but not yet delivered is discarded.
- Timestamp:
  - TS_W-bit counter; +1 on each clock where timestep_tick=1.
  - Wraps from 2^TS_W-1 to 0 with no flag.
- FSM (all outputs registered or decoded from state):
  - IDLE: if snn_event_n==0, go to POP.
  - POP: snn_ren=1 for exactly this cycle, then go to CAPTURE.
  - CAPTURE: latch evt_data <= {timestamp, neuron_addr_in}. The timestamp is the pre-increment value if a tick coincides. Increment the counter for that neuron, then go to SEND.
  - SEND: evt_valid=1. evt_data is held stable until evt_ready=1.
    - On a handshake with snn_event_n==0, go directly to POP.
    - On a handshake with snn_event_n==1, go to IDLE.
- Throughput and latency:
  - Best case is one event per 3 cycles.
  - From snn_event_n falling in IDLE to evt_valid=1 is 3 cycles.
- snn_ren is never asserted while snn_event_n==1 in the same cycle it is issued. The decision to pop is made on the cycle before, and the FIFO guarantees empty is stable until popped.
- Backpressure: evt_ready=0 holds SEND indefinitely. No further pops occur, so the FIFO absorbs the backlog.
- Counters:
  - NEURONS x CNT_W, unsigned, saturating at 2^CNT_W-1.
  - An increment while a counter is at max leaves it at max and sets cnt_sat.
- cnt_clear:
  - Zeroes all counters and cnt_sat on the next edge.
  - If it coincides with a CAPTURE increment, clear wins and the increment is dropped. The event is still delivered on evt_data.
- Counter read: cnt_rd_data <= counter[cnt_rd_addr] every cycle.
  - A same-cycle increment to the addressed counter is visible on the following read, not the current one.
  - An out-of-range cnt_rd_addr (>= NEURONS) returns 0.
- The timestamp is not affected by cnt_clear.

Test Plan:
- Reset, then FIFO non-empty with addr=5 and timestamp=0, evt_ready=1 -> snn_ren pulses at cycle 1; evt_valid at cycle 3 with evt_data={12'd0,4'd5}; counter[5] reads 1.
- Three queued events 2,7,2, evt_ready tied 1 -> snn_ren pulses 3 cycles apart with no IDLE gap; counter[2]=2, counter[7]=1.
- evt_ready=0 for 10 cycles with 4 events queued -> exactly one snn_ren; evt_data stable; evt_valid held; resumes on ready.
- 255 events to neuron 3, then a 256th -> counter[3]=255 and cnt_sat=1; cnt_clear -> counter[3]=0 and cnt_sat=0 next cycle. Clear coinciding with CAPTURE of neuron 3 -> counter stays 0.
- Timestamp advanced to 4095 plus one tick -> wraps to 0. A tick in the same cycle as CAPTURE -> the stamp uses the pre-increment value.
- Reset asserted during SEND -> evt_valid drops immediately (async); counters and timestamp return to 0; no extra snn_ren after release until snn_event_n==0.
